// File: rtl/scan_pkg.sv
// Shared types and elaboration helpers for the antenna scan sequencer.
package scan_pkg;

    // Sequencer states; encoding is fixed so captures read the same across builds.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROTATE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_GUARD  = 3'd3,
        ST_ACQ    = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } scan_state_e;

    // Default build: 4 RF channels, half-degree steps over a full turn.
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_ROT_W     = 10;
    localparam int DEF_ROT_STEPS = 720;
    localparam int DEF_T_ROT     = 5;
    localparam int DEF_T_SETTLE  = 100;
    localparam int DEF_T_GUARD   = 3;
    localparam int DEF_T_ACQ     = 30;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Largest of the four timing parameters; sizes the shared tick counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Brings the free-running step clock into the fpga_clk domain and turns each
// rising edge into a single-cycle step_tick. step_tick rises on the third
// fpga_clk edge, counting the edge that first samples stp_clk high.
module step_edge_sync (
    input  logic fpga_clk,
    input  logic sys_init_ctrl,
    input  logic stp_clk,
    output logic step_tick
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic tick_q;

    // Two-flop synchroniser, one history flop, registered rising-edge pulse.
    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            meta_q <= stp_clk;
            sync_q <= meta_q;
            prev_q <= sync_q;
            tick_q <= sync_q & ~prev_q;
        end
    end

    assign step_tick = tick_q;

endmodule

// File: rtl/scan_sequencer.sv
// Rotate / switch / acquire sequencer for the antenna scan front end.
// Each position: one motor step window, a settle wait, then a guard plus ADC
// window for every channel in the mask latched at trigger time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for trg_ctrl; outputs quiet, rot_count holds last scan
//   ROTATE | rot_en high for T_ROT step ticks
//   SETTLE | motor stopped, RF switch open, T_SETTLE ticks
//   GUARD  | RF switch on current channel, ADC off, T_GUARD ticks
//   ACQ    | ADC window on current channel, T_ACQ ticks
//   NEXT   | one cycle: bump rot_count, decide DONE or another position
//   DONE   | one cycle: scan_done pulse, drop wrk_stat
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ROT_W     = DEF_ROT_W,
    parameter int ROT_STEPS = DEF_ROT_STEPS,
    parameter int T_ROT     = DEF_T_ROT,
    parameter int T_SETTLE  = DEF_T_SETTLE,
    parameter int T_GUARD   = DEF_T_GUARD,
    parameter int T_ACQ     = DEF_T_ACQ
) (
    input  logic                          fpga_clk,
    input  logic                          sys_init_ctrl,
    input  logic                          stp_clk,
    input  logic                          trg_ctrl,
    input  logic                          abort,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic [ROT_W-1:0]              rot_target,
    output logic                          wrk_stat,
    output logic                          rot_en,
    output logic                          adc_en,
    output logic [NUM_CH-1:0]             rf_sw,
    output logic [clog2_min1(NUM_CH)-1:0] ch_idx,
    output logic [ROT_W-1:0]              rot_count,
    output logic                          scan_done
);

    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int T_MAX  = max4(T_ROT, T_SETTLE, T_GUARD, T_ACQ);
    localparam int TCNT_W = clog2_min1(T_MAX) + 1;

    // Down-counter reload values: a state ends on the tick seen at count 0.
    localparam logic [TCNT_W-1:0] LD_ROT    = TCNT_W'(T_ROT - 1);
    localparam logic [TCNT_W-1:0] LD_SETTLE = TCNT_W'(T_SETTLE - 1);
    localparam logic [TCNT_W-1:0] LD_GUARD  = TCNT_W'(T_GUARD - 1);
    localparam logic [TCNT_W-1:0] LD_ACQ    = TCNT_W'(T_ACQ - 1);
    localparam logic [ROT_W-1:0]  STEPS     = ROT_W'(ROT_STEPS);

    if (T_ROT < 1 || T_SETTLE < 1 || T_GUARD < 1 || T_ACQ < 1) begin : g_bad_timing
        $error("scan_sequencer: every T_* timing parameter must be at least 1");
    end

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("scan_sequencer: NUM_CH must be at least 1");
    end

    // rot_count must reach the default target without wrapping.
    if (ROT_STEPS < 1 || longint'(ROT_STEPS) >= (longint'(1) << ROT_W)) begin : g_bad_steps
        $error("scan_sequencer: ROT_STEPS must be in 1 .. 2**ROT_W-1");
    end

    scan_state_e         state_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [ROT_W-1:0]    target_q;
    logic                wrk_stat_q;
    logic                rot_en_q;
    logic                adc_en_q;
    logic [NUM_CH-1:0]   rf_sw_q;
    logic [CH_W-1:0]     ch_idx_q;
    logic [ROT_W-1:0]    rot_count_q;
    logic                scan_done_q;

    logic                step_tick;
    logic                tcnt_zero;
    logic [ROT_W-1:0]    eff_target;
    logic [ROT_W-1:0]    count_inc;
    logic                first_vld;
    logic [CH_W-1:0]     first_idx;
    logic                next_vld;
    logic [CH_W-1:0]     next_idx;

    step_edge_sync u_step_sync (
        .fpga_clk      (fpga_clk),
        .sys_init_ctrl (sys_init_ctrl),
        .stp_clk       (stp_clk),
        .step_tick     (step_tick)
    );

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign tcnt_zero  = (tcnt_q == '0);
    assign eff_target = (target_q == '0) ? STEPS : target_q;
    assign count_inc  = rot_count_q + ROT_W'(1);

    // Priority search on the latched mask: lowest enabled channel, and the
    // lowest enabled channel strictly above the one currently selected.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_vld = 1'b1;
                first_idx = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_idx_q))) begin
                next_vld = 1'b1;
                next_idx = CH_W'(i);
            end
        end
    end

    // Sequencer FSM with tick counter and registered outputs.
    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            mask_q      <= '0;
            target_q    <= '0;
            wrk_stat_q  <= 1'b0;
            rot_en_q    <= 1'b0;
            adc_en_q    <= 1'b0;
            rf_sw_q     <= '0;
            ch_idx_q    <= '0;
            rot_count_q <= '0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                // Abort drops every drive line at once; rot_count keeps progress.
                state_q    <= ST_IDLE;
                tcnt_q     <= '0;
                wrk_stat_q <= 1'b0;
                rot_en_q   <= 1'b0;
                adc_en_q   <= 1'b0;
                rf_sw_q    <= '0;
                ch_idx_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trg_ctrl && !abort) begin
                            mask_q      <= ch_mask;
                            target_q    <= rot_target;
                            rot_count_q <= '0;
                            wrk_stat_q  <= 1'b1;
                            rot_en_q    <= 1'b1;
                            tcnt_q      <= LD_ROT;
                            state_q     <= ST_ROTATE;
                        end
                    end
                    ST_ROTATE: begin
                        if (step_tick) begin
                            if (tcnt_zero) begin
                                rot_en_q <= 1'b0;
                                tcnt_q   <= LD_SETTLE;
                                state_q  <= ST_SETTLE;
                            end else begin
                                tcnt_q <= tcnt_q - TCNT_W'(1);
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (step_tick) begin
                            if (tcnt_zero) begin
                                if (first_vld) begin
                                    rf_sw_q  <= ch_onehot(first_idx);
                                    ch_idx_q <= first_idx;
                                    tcnt_q   <= LD_GUARD;
                                    state_q  <= ST_GUARD;
                                end else begin
                                    // Empty mask: rotate-only scan.
                                    state_q <= ST_NEXT;
                                end
                            end else begin
                                tcnt_q <= tcnt_q - TCNT_W'(1);
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (step_tick) begin
                            if (tcnt_zero) begin
                                adc_en_q <= 1'b1;
                                tcnt_q   <= LD_ACQ;
                                state_q  <= ST_ACQ;
                            end else begin
                                tcnt_q <= tcnt_q - TCNT_W'(1);
                            end
                        end
                    end
                    ST_ACQ: begin
                        if (step_tick) begin
                            if (tcnt_zero) begin
                                // ADC closes on the same edge the switch moves on.
                                adc_en_q <= 1'b0;
                                if (next_vld) begin
                                    rf_sw_q  <= ch_onehot(next_idx);
                                    ch_idx_q <= next_idx;
                                    tcnt_q   <= LD_GUARD;
                                    state_q  <= ST_GUARD;
                                end else begin
                                    rf_sw_q  <= '0;
                                    ch_idx_q <= '0;
                                    state_q  <= ST_NEXT;
                                end
                            end else begin
                                tcnt_q <= tcnt_q - TCNT_W'(1);
                            end
                        end
                    end
                    ST_NEXT: begin
                        rot_count_q <= count_inc;
                        if (count_inc == eff_target) begin
                            scan_done_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            rot_en_q <= 1'b1;
                            tcnt_q   <= LD_ROT;
                            state_q  <= ST_ROTATE;
                        end
                    end
                    ST_DONE: begin
                        wrk_stat_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wrk_stat  = wrk_stat_q;
    assign rot_en    = rot_en_q;
    assign adc_en    = adc_en_q;
    assign rf_sw     = rf_sw_q;
    assign ch_idx    = ch_idx_q;
    assign rot_count = rot_count_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer. A monitor compresses the DUT outputs into
// segments of constant value, each tagged with the number of stp_clk rising
// edges seen while it lasted. The expected segment list is built from the
// scan rules (positions x channels x durations in ticks).
module tb_scan_sequencer;

    localparam int NUM_CH    = 4;
    localparam int ROT_W     = 10;
    localparam int ROT_STEPS = 720;
    localparam int T_ROT     = 2;
    localparam int T_SETTLE  = 4;
    localparam int T_GUARD   = 1;
    localparam int T_ACQ     = 3;

    logic                fpga_clk;
    logic                sys_init_ctrl;
    logic                stp_clk;
    logic                trg_ctrl;
    logic                abort;
    logic [NUM_CH-1:0]   ch_mask;
    logic [ROT_W-1:0]    rot_target;
    logic                wrk_stat;
    logic                rot_en;
    logic                adc_en;
    logic [NUM_CH-1:0]   rf_sw;
    logic [1:0]          ch_idx;
    logic [ROT_W-1:0]    rot_count;
    logic                scan_done;

    int vectors     = 0;
    int miscompares = 0;
    int phase       = 0;
    int prev_count  = 0;

    bit          mon_en   = 1'b0;
    bit          seg_open = 1'b0;
    bit          stp_prev = 1'b0;
    logic [19:0] seg_tup;
    int          seg_rises;
    logic [19:0] obs_tup[$];
    int          obs_rise[$];
    logic [19:0] exp_tup[$];
    int          exp_rise[$];

    scan_sequencer #(
        .NUM_CH    (NUM_CH),
        .ROT_W     (ROT_W),
        .ROT_STEPS (ROT_STEPS),
        .T_ROT     (T_ROT),
        .T_SETTLE  (T_SETTLE),
        .T_GUARD   (T_GUARD),
        .T_ACQ     (T_ACQ)
    ) u_dut (
        .fpga_clk      (fpga_clk),
        .sys_init_ctrl (sys_init_ctrl),
        .stp_clk       (stp_clk),
        .trg_ctrl      (trg_ctrl),
        .abort         (abort),
        .ch_mask       (ch_mask),
        .rot_target    (rot_target),
        .wrk_stat      (wrk_stat),
        .rot_en        (rot_en),
        .adc_en        (adc_en),
        .rf_sw         (rf_sw),
        .ch_idx        (ch_idx),
        .rot_count     (rot_count),
        .scan_done     (scan_done)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    // Step clock at 1/7 of fpga_clk, 3 high / 4 low, changing 2 ns after posedge.
    initial stp_clk = 1'b0;
    always @(posedge fpga_clk) begin
        #2;
        phase   = (phase == 6) ? 0 : phase + 1;
        stp_clk = (phase < 3);
    end

    // Segment recorder, sampling on the falling edge.
    always @(negedge fpga_clk) begin
        logic [19:0] cur;
        bit          rise_now;
        cur      = {scan_done, wrk_stat, rot_en, adc_en, rf_sw, ch_idx, rot_count};
        rise_now = stp_clk && !stp_prev;
        stp_prev = stp_clk;
        if (mon_en) begin
            if (!seg_open) begin
                seg_open  = 1'b1;
                seg_tup   = cur;
                seg_rises = 0;
            end else if (cur !== seg_tup) begin
                obs_tup.push_back(seg_tup);
                obs_rise.push_back(seg_rises);
                seg_tup   = cur;
                seg_rises = 0;
            end
            if (rise_now) seg_rises++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [19:0] tup(input bit sd, input bit wk, input bit re, input bit ae,
                                        input logic [3:0] rf, input int ci, input int rc);
        return {sd, wk, re, ae, rf, 2'(ci), 10'(rc)};
    endfunction

    task automatic push_exp(input logic [19:0] t, input int rises);
        exp_tup.push_back(t);
        exp_rise.push_back(rises);
    endtask

    // Trigger so the accept edge lands 5 samples after a stp_clk rise: the
    // previous tick is already spent in IDLE and the next one falls in ROTATE.
    task automatic start_scan(input logic [3:0] m, input logic [9:0] tgt);
        @(negedge fpga_clk);
        for (int k = 0; k < 8 && phase != 4; k++) @(negedge fpga_clk);
        ch_mask    = m;
        rot_target = tgt;
        trg_ctrl   = 1'b1;
        @(negedge fpga_clk);
        trg_ctrl   = 1'b0;
        ch_mask    = 4'($urandom);
        rot_target = 10'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit finished);
        finished = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge fpga_clk);
            if (!wrk_stat) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_scan(input logic [3:0] m, input logic [9:0] tgt, input string name);
        int          n;
        bit          finished;
        logic [3:0]  oh;
        n = (tgt == 0) ? ROT_STEPS : int'(tgt);
        exp_tup.delete();  exp_rise.delete();
        obs_tup.delete();  obs_rise.delete();
        push_exp(tup(0, 0, 0, 0, 4'b0, 0, prev_count), -1);
        for (int p = 0; p < n; p++) begin
            push_exp(tup(0, 1, 1, 0, 4'b0, 0, p), T_ROT);
            push_exp(tup(0, 1, 0, 0, 4'b0, 0, p), T_SETTLE);
            for (int c = 0; c < NUM_CH; c++) begin
                if (m[c]) begin
                    oh = 4'b0001 << c;
                    push_exp(tup(0, 1, 0, 0, oh, c, p), T_GUARD);
                    push_exp(tup(0, 1, 0, 1, oh, c, p), T_ACQ);
                end
            end
            if (m != 4'b0) push_exp(tup(0, 1, 0, 0, 4'b0, 0, p), 0);
        end
        push_exp(tup(1, 1, 0, 0, 4'b0, 0, n), 0);
        push_exp(tup(0, 0, 0, 0, 4'b0, 0, n), -1);

        @(posedge fpga_clk);
        mon_en = 1'b1;
        start_scan(m, tgt);
        wait_idle(n * 170 + 200, finished);
        check({name, " completes"}, 32'(finished), 32'd1);
        repeat (3) @(negedge fpga_clk);
        @(posedge fpga_clk);
        mon_en = 1'b0;
        if (seg_open) begin
            obs_tup.push_back(seg_tup);
            obs_rise.push_back(seg_rises);
            seg_open = 1'b0;
        end
        check({name, " segment count"}, 32'(obs_tup.size()), 32'(exp_tup.size()));
        for (int i = 0; i < exp_tup.size() && i < obs_tup.size(); i++) begin
            check($sformatf("%s seg%0d outputs", name, i), 32'(obs_tup[i]), 32'(exp_tup[i]));
            if (exp_rise[i] >= 0)
                check($sformatf("%s seg%0d ticks", name, i), 32'(obs_rise[i]), 32'(exp_rise[i]));
        end
        prev_count = n;
    endtask

    initial begin
        bit         found;
        bit         finished;
        int         sd_seen;
        logic [3:0] m_r;
        logic [9:0] t_r;

        sys_init_ctrl = 1'b1;
        trg_ctrl      = 1'b0;
        abort         = 1'b0;
        ch_mask       = '0;
        rot_target    = '0;
        repeat (4) @(negedge fpga_clk);
        check("reset wrk_stat",  32'(wrk_stat),  32'd0);
        check("reset rot_en",    32'(rot_en),    32'd0);
        check("reset adc_en",    32'(adc_en),    32'd0);
        check("reset rf_sw",     32'(rf_sw),     32'd0);
        check("reset ch_idx",    32'(ch_idx),    32'd0);
        check("reset rot_count", 32'(rot_count), 32'd0);
        check("reset scan_done", 32'(scan_done), 32'd0);
        sys_init_ctrl = 1'b0;
        repeat (3) @(negedge fpga_clk);

        run_scan(4'b1111, 10'd2, "all4");
        run_scan(4'b0101, 10'd1, "ch0ch2");
        run_scan(4'b0000, 10'd3, "rotonly");
        for (int r = 0; r < 4; r++) begin
            m_r = 4'($urandom_range(0, 15));
            t_r = 10'($urandom_range(1, 3));
            run_scan(m_r, t_r, $sformatf("rand%0d", r));
        end

        // Abort during the second ACQ window of position 1.
        start_scan(4'b1111, 10'd2);
        found = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge fpga_clk);
            if (rot_count == 10'd1 && adc_en && ch_idx == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("abort point reached", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge fpga_clk);
        abort = 1'b0;
        check("abort rot_en",    32'(rot_en),    32'd0);
        check("abort adc_en",    32'(adc_en),    32'd0);
        check("abort rf_sw",     32'(rf_sw),     32'd0);
        check("abort ch_idx",    32'(ch_idx),    32'd0);
        check("abort wrk_stat",  32'(wrk_stat),  32'd0);
        check("abort rot_count", 32'(rot_count), 32'd1);
        check("abort scan_done", 32'(scan_done), 32'd0);
        sd_seen = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge fpga_clk);
            if (scan_done || wrk_stat || rot_en) sd_seen++;
        end
        check("quiet after abort", 32'(sd_seen), 32'd0);

        // Trigger together with abort in IDLE is refused.
        trg_ctrl = 1'b1;
        abort    = 1'b1;
        repeat (3) @(negedge fpga_clk);
        trg_ctrl = 1'b0;
        abort    = 1'b0;
        @(negedge fpga_clk);
        check("trg+abort idle wrk_stat", 32'(wrk_stat),  32'd0);
        check("trg+abort rot_count",     32'(rot_count), 32'd1);

        // Retrigger clears rot_count at accept.
        start_scan(4'b1000, 10'd1);
        check("retrigger rot_count", 32'(rot_count), 32'd0);
        check("retrigger wrk_stat",  32'(wrk_stat),  32'd1);
        wait_idle(400, finished);
        check("retrigger completes", 32'(finished),  32'd1);
        check("retrigger final",     32'(rot_count), 32'd1);
        prev_count = 1;

        // Reset mid-GUARD with a trigger in the same cycle.
        start_scan(4'b0011, 10'd2);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge fpga_clk);
            if (rf_sw != 4'b0 && !adc_en) begin
                found = 1'b1;
                break;
            end
        end
        check("guard reached", 32'(found), 32'd1);
        sys_init_ctrl = 1'b1;
        trg_ctrl      = 1'b1;
        @(negedge fpga_clk);
        sys_init_ctrl = 1'b0;
        trg_ctrl      = 1'b0;
        check("midreset outputs", 32'({scan_done, wrk_stat, rot_en, adc_en, rf_sw, ch_idx, rot_count}), 32'd0);
        repeat (20) @(negedge fpga_clk);
        check("midreset stays idle", 32'({wrk_stat, rot_en}), 32'd0);
        prev_count = 0;

        // Default-length rotate-only scan.
        run_scan(4'b0000, 10'd0, "full720");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
